// File: rtl/store_buffer_ctrl_pkg.sv
// Shared definitions for the MEM-stage store buffer: store-type codes,
// FSM encoding and byte-enable width helper.
package store_buffer_ctrl_pkg;

  localparam logic [1:0] ST_WORD = 2'b00;
  localparam logic [1:0] ST_BYTE = 2'b01;
  localparam logic [1:0] ST_HALF = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  function automatic int be_width(input int nbits);
    return nbits / 8;
  endfunction

endpackage

// File: rtl/store_buffer_ctrl_aligner.sv
// Combinational store aligner: legality check, word address, byte-lane
// enables and lane-replicated write data for SW/SH/SB.
module store_aligner
  import store_buffer_ctrl_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int TNBITS = 2
) (
  input  logic [TNBITS-1:0]         store_type,
  input  logic [NBITS-1:0]          addr,
  input  logic [NBITS-1:0]          rt,
  output logic                      legal,
  output logic [NBITS-1:0]          word_addr,
  output logic [be_width(NBITS)-1:0] be,
  output logic [NBITS-1:0]          wdata
);

  localparam int BEW = be_width(NBITS);

  logic [1:0] off;

  assign off       = addr[1:0];
  assign word_addr = {addr[NBITS-1:2], 2'b00};

  always_comb begin
    legal = 1'b0;
    be    = '0;
    wdata = rt;
    case (store_type)
      TNBITS'(ST_WORD): begin
        legal = (off == 2'b00);
        be    = '1;
        wdata = rt;
      end
      TNBITS'(ST_HALF): begin
        legal = ~off[0];
        be    = BEW'(3) << off;
        wdata = {(NBITS/16){rt[15:0]}};
      end
      TNBITS'(ST_BYTE): begin
        legal = 1'b1;
        be    = BEW'(1) << off;
        wdata = {(NBITS/8){rt[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_buffer_ctrl.sv
// Posted-write store buffer: queues aligned stores in a FIFO, drains them to
// data memory over a valid/ack handshake and flags load RAW hazards.
module store_buffer_ctrl
  import store_buffer_ctrl_pkg::*;
#(
  parameter int NBITS   = 32,
  parameter int TNBITS  = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_store_valid,
  input  logic [TNBITS-1:0]  i_store_type,
  input  logic [NBITS-1:0]   i_addr,
  input  logic [NBITS-1:0]   i_dato_rt,
  output logic               o_store_ready,
  input  logic               i_load_valid,
  input  logic [NBITS-1:0]   i_load_addr,
  output logic               o_load_stall,
  output logic               o_mem_we,
  output logic [NBITS-1:0]   o_mem_addr,
  output logic [NBITS/8-1:0] o_mem_be,
  output logic [NBITS-1:0]   o_mem_wdata,
  input  logic               i_mem_ack,
  output logic               o_empty,
  output logic               o_store_err,
  output logic               o_timeout
);

  localparam int BEW = be_width(NBITS);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [WDW-1:0]  wd;

  logic [NBITS-1:0] q_addr  [DEPTH];
  logic [BEW-1:0]   q_be    [DEPTH];
  logic [NBITS-1:0] q_wdata [DEPTH];

  logic             a_legal;
  logic [NBITS-1:0] a_addr;
  logic [BEW-1:0]   a_be;
  logic [NBITS-1:0] a_wdata;

  logic             push;
  logic             pop;
  logic             hit;
  logic [AW-1:0]    rel;
  logic [NBITS-1:0] load_wa;

  store_aligner #(
    .NBITS  (NBITS),
    .TNBITS (TNBITS)
  ) u_aligner (
    .store_type (i_store_type),
    .addr       (i_addr),
    .rt         (i_dato_rt),
    .legal      (a_legal),
    .word_addr  (a_addr),
    .be         (a_be),
    .wdata      (a_wdata)
  );

  // Ready depends only on registered count, never on this cycle's ack.
  assign o_store_ready = (count < CW'(DEPTH));
  assign push          = i_store_valid & o_store_ready & a_legal;
  assign pop           = (state == WRITE) & i_mem_ack;
  assign count_nxt     = count + CW'(push) - CW'(pop);

  assign o_mem_we    = (state == WRITE);
  assign o_mem_addr  = q_addr[rd_ptr];
  assign o_mem_be    = q_be[rd_ptr];
  assign o_mem_wdata = q_wdata[rd_ptr];
  assign o_empty     = (count == '0) && (state == IDLE);

  assign load_wa = i_load_addr & {{(NBITS-2){1'b1}}, 2'b00};

  // Word-granular hazard: every occupied slot (head included) plus the
  // store being accepted right now.
  always_comb begin
    hit = 1'b0;
    rel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = AW'(i) - rd_ptr;
      if ((CW'(rel) < count) && (q_addr[i] == load_wa))
        hit = 1'b1;
    end
    if (push && (a_addr == load_wa))
      hit = 1'b1;
  end

  assign o_load_stall = i_load_valid & hit;

  always_ff @(posedge i_clk) begin
    if (push) begin
      q_addr[wr_ptr]  <= a_addr;
      q_be[wr_ptr]    <= a_be;
      q_wdata[wr_ptr] <= a_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wd          <= '0;
      o_store_err <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_store_err <= i_store_valid & ~a_legal;
      count       <= count_nxt;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case (state)
        IDLE: begin
          wd <= '0;
          if (count != '0)
            state <= WRITE;
        end
        WRITE: begin
          if (i_mem_ack) begin
            wd <= '0;
            if (count_nxt == '0)
              state <= IDLE;
          end else begin
            if (wd != WDW'(TIMEOUT))
              wd <= wd + WDW'(1);
            if (wd == WDW'(TIMEOUT - 1))
              o_timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Directed bench for store_buffer_ctrl with a queue-based write scoreboard.
module tb_store_buffer_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_store_valid;
  logic [1:0]  i_store_type;
  logic [31:0] i_addr;
  logic [31:0] i_dato_rt;
  logic        o_store_ready;
  logic        i_load_valid;
  logic [31:0] i_load_addr;
  logic        o_load_stall;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic        o_empty;
  logic        o_store_err;
  logic        o_timeout;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 i_clk = ~i_clk;

  store_buffer_ctrl #(
    .NBITS   (32),
    .TNBITS  (2),
    .DEPTH   (4),
    .TIMEOUT (255)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_store_valid (i_store_valid),
    .i_store_type  (i_store_type),
    .i_addr        (i_addr),
    .i_dato_rt     (i_dato_rt),
    .o_store_ready (o_store_ready),
    .i_load_valid  (i_load_valid),
    .i_load_addr   (i_load_addr),
    .o_load_stall  (o_load_stall),
    .o_mem_we      (o_mem_we),
    .o_mem_addr    (o_mem_addr),
    .o_mem_be      (o_mem_be),
    .o_mem_wdata   (o_mem_wdata),
    .i_mem_ack     (i_mem_ack),
    .o_empty       (o_empty),
    .o_store_err   (o_store_err),
    .o_timeout     (o_timeout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted memory write must match the oldest expectation.
  always @(negedge i_clk) begin
    if (!i_reset && o_mem_we && i_mem_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h expected=none", o_mem_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(o_mem_addr), 64'(e.addr));
        chk("wr_be", 64'(o_mem_be), 64'(e.be));
        chk("wr_wdata", 64'(o_mem_wdata), 64'(e.wdata));
      end
    end
  end

  task automatic expect_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    exp_t e;
    e.addr  = a;
    e.be    = be;
    e.wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic do_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    i_store_valid = 1'b1;
    i_store_type  = t;
    i_addr        = a;
    i_dato_rt     = d;
    @(posedge i_clk);
    #1;
    i_store_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge i_clk);
      if (o_empty && exp_q.size() == 0)
        done = 1'b1;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    i_reset       = 1'b1;
    i_store_valid = 1'b0;
    i_store_type  = 2'b00;
    i_addr        = '0;
    i_dato_rt     = '0;
    i_load_valid  = 1'b0;
    i_load_addr   = '0;
    i_mem_ack     = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst_we", 64'(o_mem_we), 64'd0);
    chk("rst_empty", 64'(o_empty), 64'd1);
    chk("rst_ready", 64'(o_store_ready), 64'd1);
    chk("rst_stall", 64'(o_load_stall), 64'd0);
    chk("rst_err", 64'(o_store_err), 64'd0);
    chk("rst_timeout", 64'(o_timeout), 64'd0);

    // Alignment with ack held high
    @(posedge i_clk); #1;
    i_mem_ack = 1'b1;
    expect_wr(32'h10, 4'b1000, 32'hDDDDDDDD);
    do_store(2'b01, 32'h13, 32'hAABBCCDD);
    @(negedge i_clk);
    chk("sb_lat0", 64'(o_mem_we), 64'd0);
    @(negedge i_clk);
    chk("sb_lat1", 64'(o_mem_we), 64'd1);
    wait_empty("sb_drain");
    @(posedge i_clk); #1;
    expect_wr(32'h20, 4'b1100, 32'h56785678);
    do_store(2'b10, 32'h22, 32'h12345678);
    @(negedge i_clk);
    chk("sh_lat0", 64'(o_mem_we), 64'd0);
    @(negedge i_clk);
    chk("sh_lat1", 64'(o_mem_we), 64'd1);
    wait_empty("sh_drain");

    // Rejected stores
    @(posedge i_clk); #1;
    do_store(2'b00, 32'h06, 32'h1);
    @(negedge i_clk);
    chk("err_sw", 64'(o_store_err), 64'd1);
    chk("err_sw_empty", 64'(o_empty), 64'd1);
    @(negedge i_clk);
    chk("err_sw_pulse", 64'(o_store_err), 64'd0);
    @(posedge i_clk); #1;
    do_store(2'b10, 32'h01, 32'h2);
    @(negedge i_clk);
    chk("err_sh", 64'(o_store_err), 64'd1);
    @(negedge i_clk);
    chk("err_sh_pulse", 64'(o_store_err), 64'd0);
    chk("err_sh_we", 64'(o_mem_we), 64'd0);
    @(posedge i_clk); #1;
    do_store(2'b11, 32'h08, 32'h3);
    @(negedge i_clk);
    chk("err_t11", 64'(o_store_err), 64'd1);
    @(negedge i_clk);
    chk("err_t11_pulse", 64'(o_store_err), 64'd0);
    chk("err_t11_empty", 64'(o_empty), 64'd1);
    chk("err_t11_we", 64'(o_mem_we), 64'd0);

    // Full buffer and back-pressure
    @(posedge i_clk); #1;
    i_mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_wr(32'h100 + 32'(4 * i), 4'b1111, 32'hA0000000 + 32'(i));
      do_store(2'b00, 32'h100 + 32'(4 * i), 32'hA0000000 + 32'(i));
    end
    @(negedge i_clk);
    chk("full_ready", 64'(o_store_ready), 64'd0);
    @(posedge i_clk); #1;
    i_store_valid = 1'b1;
    i_store_type  = 2'b00;
    i_addr        = 32'h500;
    i_dato_rt     = 32'hBAD0BAD0;
    i_mem_ack     = 1'b1;
    @(negedge i_clk);
    chk("full_ready_pop", 64'(o_store_ready), 64'd0);
    @(posedge i_clk); #1;
    i_store_valid = 1'b0;
    i_mem_ack     = 1'b0;
    @(negedge i_clk);
    chk("after_pop_ready", 64'(o_store_ready), 64'd1);
    chk("after_pop_q", 64'(exp_q.size()), 64'd3);
    @(posedge i_clk); #1;
    i_mem_ack = 1'b1;
    wait_empty("full_drain");
    chk("full_empty", 64'(o_empty), 64'd1);

    // Back-to-back writes
    @(posedge i_clk); #1;
    i_mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_wr(32'h200 + 32'(4 * i), 4'b1111, 32'hC0DE0000 + 32'(i));
      do_store(2'b00, 32'h200 + 32'(4 * i), 32'hC0DE0000 + 32'(i));
    end
    repeat (3) @(posedge i_clk);
    #1;
    i_mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("b2b_we", 64'(o_mem_we), 64'd1);
    end
    @(negedge i_clk);
    chk("b2b_idle", 64'(o_mem_we), 64'd0);
    chk("b2b_empty", 64'(o_empty), 64'd1);

    // Load hazard
    @(posedge i_clk); #1;
    i_mem_ack = 1'b0;
    expect_wr(32'h40, 4'b1111, 32'h11111111);
    do_store(2'b00, 32'h40, 32'h11111111);
    i_load_valid = 1'b1;
    i_load_addr  = 32'h42;
    @(negedge i_clk);
    chk("haz_match", 64'(o_load_stall), 64'd1);
    i_load_addr = 32'h44;
    #1;
    chk("haz_nomatch", 64'(o_load_stall), 64'd0);
    i_load_valid = 1'b0;
    i_load_addr  = 32'h42;
    #1;
    chk("haz_noload", 64'(o_load_stall), 64'd0);
    i_load_valid  = 1'b1;
    i_load_addr   = 32'h80;
    i_store_valid = 1'b1;
    i_store_type  = 2'b00;
    i_addr        = 32'h80;
    i_dato_rt     = 32'h22222222;
    expect_wr(32'h80, 4'b1111, 32'h22222222);
    #1;
    chk("haz_incoming", 64'(o_load_stall), 64'd1);
    @(posedge i_clk); #1;
    i_store_valid = 1'b0;
    i_load_addr   = 32'h42;
    repeat (2) @(posedge i_clk);
    #1;
    i_mem_ack = 1'b1;
    @(negedge i_clk);
    chk("haz_hold", 64'(o_load_stall), 64'd1);
    @(posedge i_clk); #1;
    i_mem_ack = 1'b0;
    @(negedge i_clk);
    chk("haz_drop", 64'(o_load_stall), 64'd0);
    i_load_valid = 1'b0;
    @(posedge i_clk); #1;
    i_mem_ack = 1'b1;
    wait_empty("haz_drain");

    // Watchdog and reset mid-operation
    @(posedge i_clk); #1;
    i_mem_ack = 1'b0;
    do_store(2'b00, 32'h300, 32'h33333333);
    repeat (200) @(negedge i_clk);
    chk("wd_early", 64'(o_timeout), 64'd0);
    repeat (100) @(negedge i_clk);
    chk("wd_fire", 64'(o_timeout), 64'd1);
    repeat (20) @(negedge i_clk);
    chk("wd_sticky", 64'(o_timeout), 64'd1);
    chk("wd_we", 64'(o_mem_we), 64'd1);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    exp_q.delete();
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst2_we", 64'(o_mem_we), 64'd0);
    chk("rst2_empty", 64'(o_empty), 64'd1);
    chk("rst2_timeout", 64'(o_timeout), 64'd0);

    repeat (2) @(posedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
